// File: rtl/rf_pkg.sv
// Shared constants and types for the register file and its read ports.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`timescale 1ns/1ps
package rf_pkg;

  // Default geometry: 8 registers of 8 bits.
  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_ADDR_WIDTH = 3;
  localparam int RF_DEPTH      = 2 ** RF_ADDR_WIDTH;

  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

endpackage

// File: rtl/rf_read_port.sv
// Combinational read port: selects one word of the flattened storage array.
// Latency: zero cycles (pure combinational mux from address to data).
// Backpressure: none; the output always reflects the current address.
//
// Ports:
//   mem_flat  flattened storage, word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_addr   word select
//   rd_data   selected word (or forwarded write data, see below)
//   byp_en / byp_addr / byp_data   present only with RF_WRITE_BYPASS_EN:
//     when byp_en is high and byp_addr matches rd_addr the port returns
//     byp_data instead of the stored word (write-first forwarding).
`timescale 1ns/1ps
module rf_read_port #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic [DEPTH*DATA_WIDTH-1:0] mem_flat,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
`ifdef RF_WRITE_BYPASS_EN
  ,
  input  logic                        byp_en,
  input  logic [ADDR_WIDTH-1:0]       byp_addr,
  input  logic [DATA_WIDTH-1:0]       byp_data
`endif
);

  logic [DATA_WIDTH-1:0] stored_word;

  // Full decode: every address value names a real word, so no range check.
  assign stored_word = mem_flat[int'(rd_addr)*DATA_WIDTH +: DATA_WIDTH];

`ifdef RF_WRITE_BYPASS_EN
  always_comb begin
    rd_data = stored_word;
    if (byp_en && (byp_addr == rd_addr)) begin
      rd_data = byp_data;
    end
  end
`else
  assign rd_data = stored_word;
`endif

endmodule

// File: rtl/register_file.sv
// Register file: 2**ADDR_WIDTH words, one synchronous write, two async reads.
// Latency: write visible after 1 rising edge; reads are zero-latency.
// Backpressure: none; a write is accepted on every edge with wr_en high.
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset clears all words
//   wr_en       write enable (active high)
//   w_addr      write address, also the address of read port B
//   r_addr      read address of port A
//   w_data      write data
//   r_data      port A data = reg[r_addr]
//   r2_data     port B data = reg[w_addr] (operand being overwritten)
//
// Build option: define RF_WRITE_BYPASS_EN for write-first forwarding, where
// a port whose address matches w_addr during a write shows w_data in the
// same cycle. Storage and write timing are the same in both builds.
`timescale 1ns/1ps
module register_file
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [DATA_WIDTH-1:0] r2_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0] mem_flat;

  // Storage and write decode. Reset clears every word immediately, so both
  // read ports drop to zero without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[w_addr] <= w_data;
    end
  end

  // Flatten the array so the read-port module can take it as a plain vector.
  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
  end

`ifdef RF_WRITE_BYPASS_EN
  // Forwarding is suppressed during reset so both ports still read zero.
  logic byp_en;
  assign byp_en = wr_en & rst_n;
`endif

  // Port A: general operand read.
  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_port_a (
    .mem_flat (mem_flat),
    .rd_addr  (r_addr),
    .rd_data  (r_data)
`ifdef RF_WRITE_BYPASS_EN
    ,
    .byp_en   (byp_en),
    .byp_addr (w_addr),
    .byp_data (w_data)
`endif
  );

  // Port B: always reads the word addressed by w_addr (accumulator fetch).
  rf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_port_b (
    .mem_flat (mem_flat),
    .rd_addr  (w_addr),
    .rd_data  (r2_data)
`ifdef RF_WRITE_BYPASS_EN
    ,
    .byp_en   (byp_en),
    .byp_addr (w_addr),
    .byp_data (w_data)
`endif
  );

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/1ps
module tb_register_file;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] w_addr;
  logic [2:0] r_addr;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic [7:0] r2_data;

  int n_tests;
  int n_fail;

  logic [7:0] fill_vals [8];
  logic [7:0] model     [8];

  register_file dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .w_addr  (w_addr),
    .r_addr  (r_addr),
    .w_data  (w_data),
    .r_data  (r_data),
    .r2_data (r2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    wr_en  = 1'b0;
    w_addr = 3'd0;
    r_addr = 3'd0;
    w_data = 8'h00;
    #1;
    for (int a = 0; a < 8; a++) begin
      r_addr = 3'(a);
      w_addr = 3'(7 - a);
      #1;
      n_tests++;
      if (r_data !== 8'h00 || r2_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_state addr=%0d r_data=%h r2_data=%h expected 00/00", a, r_data, r2_data);
      end
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [7:0] exp_b;
    for (int i = 0; i < 8; i++) begin
      wr_en  = 1'b1;
      w_addr = 3'(i);
      w_data = fill_vals[i];
      r_addr = (i == 0) ? 3'd0 : 3'(i - 1);
      #1;
`ifdef RF_WRITE_BYPASS_EN
      exp_b = fill_vals[i];
`else
      exp_b = 8'h00;
`endif
      n_tests++;
      if (r2_data !== exp_b) begin
        n_fail++;
        $display("FAIL fill_r2 addr=%0d r2_data=%h expected %h", i, r2_data, exp_b);
      end
      if (i > 0) begin
        n_tests++;
        if (r_data !== fill_vals[i-1]) begin
          n_fail++;
          $display("FAIL fill_prev addr=%0d r_data=%h expected %h", i - 1, r_data, fill_vals[i-1]);
        end
      end
      step();
    end
    wr_en  = 1'b0;
    r_addr = 3'd7;
    #1;
    n_tests++;
    if (r_data !== 8'h38) begin
      n_fail++;
      $display("FAIL fill_last r_data=%h expected 38", r_data);
    end
  endtask

  task automatic test_overwrite();
    logic [7:0] exp_a;
    r_addr = 3'd7;
    wr_en  = 1'b1;
    w_addr = 3'd7;
    w_data = 8'h68;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    exp_a = 8'h68;
`else
    exp_a = 8'h38;
`endif
    n_tests++;
    if (r_data !== exp_a) begin
      n_fail++;
      $display("FAIL overwrite_pre r_data=%h expected %h", r_data, exp_a);
    end
    step();
    w_data = 8'h00;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    exp_a = 8'h00;
`else
    exp_a = 8'h68;
`endif
    n_tests++;
    if (r_data !== exp_a) begin
      n_fail++;
      $display("FAIL overwrite_mid r_data=%h expected %h", r_data, exp_a);
    end
    step();
    wr_en = 1'b0;
    #1;
    n_tests++;
    if (r_data !== 8'h00 || r2_data !== 8'h00) begin
      n_fail++;
      $display("FAIL overwrite_post r_data=%h r2_data=%h expected 00/00", r_data, r2_data);
    end
  endtask

  task automatic test_same_addr();
    logic [7:0] exp_v;
    wr_en  = 1'b1;
    w_addr = 3'd0;
    r_addr = 3'd0;
    w_data = 8'h0F;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    exp_v = 8'h0F;
`else
    exp_v = 8'h45;
`endif
    n_tests++;
    if (r_data !== exp_v || r2_data !== exp_v) begin
      n_fail++;
      $display("FAIL same_addr_pre r_data=%h r2_data=%h expected %h", r_data, r2_data, exp_v);
    end
    step();
    wr_en = 1'b0;
    #1;
    n_tests++;
    if (r_data !== 8'h0F || r2_data !== 8'h0F) begin
      n_fail++;
      $display("FAIL same_addr_post r_data=%h r2_data=%h expected 0f", r_data, r2_data);
    end
  endtask

  task automatic test_write_disable();
    wr_en  = 1'b0;
    w_addr = 3'd3;
    r_addr = 3'd3;
    w_data = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      n_tests++;
      if (r2_data !== 8'h4B || r_data !== 8'h4B) begin
        n_fail++;
        $display("FAIL write_disable edge=%0d r_data=%h r2_data=%h expected 4b", k, r_data, r2_data);
      end
    end
  endtask

  task automatic test_port_b();
    wr_en  = 1'b0;
    r_addr = 3'd5;
    w_data = 8'hAA;
    for (int a = 0; a < 8; a++) begin
      w_addr = 3'(a);
      #1;
      n_tests++;
      if (r2_data !== model[a] || r_data !== 8'h0F) begin
        n_fail++;
        $display("FAIL port_b addr=%0d r2_data=%h expected %h r_data=%h expected 0f",
                 a, r2_data, model[a], r_data);
      end
    end
  endtask

  task automatic test_reset_midrun();
    step();
    wr_en  = 1'b1;
    w_addr = 3'd4;
    r_addr = 3'd6;
    w_data = 8'h5A;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (r_data !== 8'h00 || r2_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_immediate r_data=%h r2_data=%h expected 00/00", r_data, r2_data);
    end
    // Hold reset with writes requested across several edges.
    repeat (3) @(posedge clk);
    step();
    wr_en = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      r_addr = 3'(a);
      w_addr = 3'(a);
      #1;
      n_tests++;
      if (r_data !== 8'h00 || r2_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_cleared addr=%0d r_data=%h r2_data=%h expected 00/00", a, r_data, r2_data);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    fill_vals[0] = 8'h45; fill_vals[1] = 8'h03; fill_vals[2] = 8'h03; fill_vals[3] = 8'h4B;
    fill_vals[4] = 8'h08; fill_vals[5] = 8'h0F; fill_vals[6] = 8'hF0; fill_vals[7] = 8'h38;
    // Contents expected after fill, overwrite and same-address tests.
    model[0] = 8'h0F; model[1] = 8'h03; model[2] = 8'h03; model[3] = 8'h4B;
    model[4] = 8'h08; model[5] = 8'h0F; model[6] = 8'hF0; model[7] = 8'h00;

    test_reset();
    test_fill();
    step();
    test_overwrite();
    step();
    test_same_addr();
    test_write_disable();
    test_port_b();
    test_reset_midrun();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parameterised multi-register storage array for the datapath: 2**ADDR_WIDTH words of DATA_WIDTH bits.
- One synchronous write port and two asynchronous (combinational) read ports.
- Port A is addressed by r_addr.
- Port B is addressed by w_addr, so the register being written is always visible on r2_data (accumulator-style operand fetch).
- Sits between the control unit and the ALU.

Parameters:
- DATA_WIDTH, 8, width of each register and of all data ports.
- ADDR_WIDTH, 3, address width; depth = 2**ADDR_WIDTH (default 8 registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset.
- wr_en  input  1  write enable, active high.
- w_addr  input  ADDR_WIDTH  write address; also the read address of port B.
- r_addr  input  ADDR_WIDTH  read address of port A.
- w_data  input  DATA_WIDTH  write data.
- r_data  output  DATA_WIDTH  port A read data = reg[r_addr].
- r2_data  output  DATA_WIDTH  port B read data = reg[w_addr].

Interface rules:
- One clock; reset is asynchronous and active-low.
- Named clk and rst_n.

Behaviour:
- Reset:
  - rst_n low clears every register to 0 immediately, independent of clk.
  - While rst_n is low: r_data = 0 and r2_data = 0, and writes are ignored.
  - Deassertion takes effect at the next rising edge; the implementation synchronises deassertion externally if needed.
- Write:
  - On a rising clk edge with rst_n high and wr_en = 1: reg[w_addr] <= w_data.
  - wr_en = 0 leaves all registers unchanged.
  - Write latency is 1 cycle.
- Read:
  - Purely combinational, zero latency.
  - r_data follows r_addr; r2_data follows w_addr, both within the same cycle.
- Read-during-write (same address, feature off):
  - Both read ports return the old stored value until the rising edge.
  - After the edge they show the new value (write-then-read visibility).
- Same register on both ports: r_addr == w_addr drives identical values on both ports.
- Every address 0..2**ADDR_WIDTH-1 is writable; no hardwired-zero register.
- Addresses are always in range (full decode), so no wrap-around or out-of-range case exists.
- Repeated writes to one address: the last write wins; each edge overwrites.
- No X propagation after reset: all outputs are defined.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- When defined:
  - Write-first forwarding: if wr_en = 1 and the read address equals w_addr, that port outputs w_data combinationally in the same cycle.
  - r2_data therefore always shows w_data while wr_en = 1.
  - r_data shows w_data when r_addr == w_addr.
  - Reset still forces 0 on both ports.
- When undefined: read-old-data behaviour as above.
- Storage and write timing are identical in both builds.

Decomposition:
- Shared package rf_pkg:
  - Constants RF_DATA_WIDTH = 8 and RF_ADDR_WIDTH = 3.
  - Derived RF_DEPTH = 2**RF_ADDR_WIDTH.
  - Typedefs rf_data_t and rf_addr_t.
- One natural sub-module, rf_read_port:
  - Combinational mux from array plus address to data.
  - Contains the optional bypass compare.
  - Instantiated twice (port A with r_addr, port B with w_addr).
- The storage array and write decode stay in the top.

Test Plan:
- Reset: assert rst_n low mid-run after registers have been written → all 8 registers read 0 on r_data and r2_data immediately, without waiting for a clock edge.
- Sequential fill:
  - Writes: reg0=0x45, reg1=0x03, reg2=0x03, reg3=0x4B, reg4=0x08, reg5=0x0F, reg6=0xF0, reg7=0x38.
  - In each cycle r_addr points to the previous address → r_data shows the prior cycle's written value (0x45, 0x03, 0x03, 0x4B, 0x08, 0x0F, 0xF0) one cycle later.
- Overwrite: write reg7=0x68, then reg7=0x00, with r_addr=7 → r_data = 0x38 before the first edge, 0x68 after it, 0x00 after the second (feature off).
- Same-address read/write: w_addr=r_addr=0, w_data=0x0F, old value 0x45 → r_data = r2_data = 0x45 until the edge, then 0x0F. With RF_WRITE_BYPASS_EN: 0x0F immediately.
- Write disable: wr_en=0, w_addr=3, w_data=0xF0, reg3=0x4B → reg3 stays 0x4B over several edges; r2_data = 0x4B.
- Port B tracking: with wr_en=0, sweep w_addr 0..7 → r2_data equals each stored value combinationally, independent of r_addr.
